// File: rtl/accel_pkg.sv
// Shared defaults, feeder state encoding and lane packing helper for the
// operand feeder and its lane buffers.
package accel_pkg;

    localparam int NUM_SIZE    = 16;
    localparam int GRID_SIZE   = 2;
    localparam int ADDRESS_LEN = 5;
    localparam int BUFFER_LEN  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } feeder_state_t;

    // Lane i of a packed per-lane vector sits at bits [(i+1)*NUM_SIZE-1 : i*NUM_SIZE].
    function automatic logic [NUM_SIZE-1:0] lane_slice(
        input logic [NUM_SIZE*GRID_SIZE-1:0] vec,
        input int unsigned                   lane
    );
        return vec[lane*NUM_SIZE +: NUM_SIZE];
    endfunction

endpackage

// File: rtl/feeder_lane.sv
// One operand lane: a beat buffer written from the load port and read back with
// a fixed skew of LANE_IDX steps, producing a registered value or zero padding.
module feeder_lane #(
    parameter int NUM_SIZE    = accel_pkg::NUM_SIZE,
    parameter int ADDRESS_LEN = accel_pkg::ADDRESS_LEN,
    parameter int BUFFER_LEN  = accel_pkg::BUFFER_LEN,
    parameter int LANE_IDX    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr_en,
    input  logic [ADDRESS_LEN-1:0] i_wr_addr,
    input  logic [NUM_SIZE-1:0]    i_wr_data,
    input  logic                   i_rd_run,
    input  logic [ADDRESS_LEN+1:0] i_rd_step,
    input  logic [ADDRESS_LEN:0]   i_rd_count,
    output logic [NUM_SIZE-1:0]    o_lane
);

    localparam int                STEP_W = ADDRESS_LEN + 2;
    localparam logic [STEP_W-1:0] LANE_T = STEP_W'(LANE_IDX);

    logic [NUM_SIZE-1:0]    r_mem [BUFFER_LEN];
    logic [NUM_SIZE-1:0]    r_lane;
    logic [STEP_W-1:0]      w_offset;
    logic                   w_in_window;
    logic [ADDRESS_LEN-1:0] w_rd_addr;
    logic [NUM_SIZE-1:0]    w_rd_data;

    // NOTE: every variable written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        w_offset    = '0;
        w_in_window = 1'b0;
        w_rd_addr   = '0;
        if (i_rd_run && (i_rd_step >= LANE_T)) begin
            w_offset    = i_rd_step - LANE_T;
            w_in_window = (w_offset < {1'b0, i_rd_count});
        end
        if (w_in_window) begin
            w_rd_addr = w_offset[ADDRESS_LEN-1:0];
        end
    end

    // The beat accepted on the start edge can be the one read for step 0.
    assign w_rd_data = (i_wr_en && (i_wr_addr == w_rd_addr)) ? i_wr_data : r_mem[w_rd_addr];

    // NOTE: the buffer has no reset; its contents are only read inside the
    // window bounded by the beat count, which is reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane <= '0;
        end else begin
            r_lane <= w_in_window ? w_rd_data : '0;
        end
    end

    assign o_lane = r_lane;

endmodule

// File: rtl/operand_feeder.sv
// Operand staging and skew controller in front of the mxu systolic array:
// buffers loaded beats, then streams them with diagonal skew and drives ce.
module operand_feeder #(
    parameter int NUM_SIZE    = accel_pkg::NUM_SIZE,
    parameter int GRID_SIZE   = accel_pkg::GRID_SIZE,
    parameter int BUFFER_LEN  = accel_pkg::BUFFER_LEN,
    parameter int ADDRESS_LEN = accel_pkg::ADDRESS_LEN
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [NUM_SIZE*GRID_SIZE-1:0] load_north,
    input  logic [NUM_SIZE*GRID_SIZE-1:0] load_west,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          ce,
    output logic [NUM_SIZE*GRID_SIZE-1:0] north_input,
    output logic [NUM_SIZE*GRID_SIZE-1:0] west_input
);

    import accel_pkg::*;

    localparam int                 COUNT_W    = ADDRESS_LEN + 1;
    localparam int                 STEP_W     = ADDRESS_LEN + 2;
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(BUFFER_LEN);
    localparam logic [STEP_W-1:0]  SKEW_STEPS = STEP_W'(2 * (GRID_SIZE - 1));

    feeder_state_t      r_state;
    feeder_state_t      w_next_state;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] w_next_count;
    logic [COUNT_W-1:0] r_n;
    logic [COUNT_W-1:0] w_next_n;
    logic [COUNT_W-1:0] w_n_eff;
    logic [STEP_W-1:0]  r_step;
    logic [STEP_W-1:0]  w_next_step;
    logic [STEP_W-1:0]  w_last_step;
    logic               w_accept;
    logic               w_rd_run;
    logic               r_load_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_ce;

    assign w_accept    = load_valid && r_load_ready;
    assign w_n_eff     = r_count + COUNT_W'(w_accept);
    // Only evaluated in RUN, where n >= 1, so the subtraction cannot wrap.
    assign w_last_step = {1'b0, r_n} + SKEW_STEPS - STEP_W'(1);

    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        w_next_step  = r_step;
        w_next_n     = r_n;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_count = w_n_eff;
                end
                if (start) begin
                    if (w_n_eff == '0) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_RUN;
                        w_next_step  = '0;
                        w_next_n     = w_n_eff;
                    end
                end
            end
            ST_RUN: begin
                if (r_step == w_last_step) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_step = r_step + STEP_W'(1);
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
                w_next_count = '0;
                w_next_step  = '0;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_step       <= '0;
            r_n          <= '0;
            r_load_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ce         <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_count      <= w_next_count;
            r_step       <= w_next_step;
            r_n          <= w_next_n;
            r_load_ready <= (w_next_state == ST_IDLE) && (w_next_count < FULL_COUNT);
            r_busy       <= (w_next_state == ST_RUN);
            r_done       <= (w_next_state == ST_DONE);
            r_ce         <= (w_next_state == ST_RUN);
        end
    end

    // Lanes register the next step's value so data lines up with ce and busy.
    assign w_rd_run = (w_next_state == ST_RUN);

    for (genvar g = 0; g < GRID_SIZE; g++) begin : g_lane
        logic [NUM_SIZE-1:0] w_north_lane;
        logic [NUM_SIZE-1:0] w_west_lane;

        feeder_lane #(
            .NUM_SIZE    (NUM_SIZE),
            .ADDRESS_LEN (ADDRESS_LEN),
            .BUFFER_LEN  (BUFFER_LEN),
            .LANE_IDX    (g)
        ) u_north (
            .clk        (clk),
            .rst        (rst),
            .i_wr_en    (w_accept),
            .i_wr_addr  (r_count[ADDRESS_LEN-1:0]),
            .i_wr_data  (load_north[g*NUM_SIZE +: NUM_SIZE]),
            .i_rd_run   (w_rd_run),
            .i_rd_step  (w_next_step),
            .i_rd_count (w_next_n),
            .o_lane     (w_north_lane)
        );

        feeder_lane #(
            .NUM_SIZE    (NUM_SIZE),
            .ADDRESS_LEN (ADDRESS_LEN),
            .BUFFER_LEN  (BUFFER_LEN),
            .LANE_IDX    (g)
        ) u_west (
            .clk        (clk),
            .rst        (rst),
            .i_wr_en    (w_accept),
            .i_wr_addr  (r_count[ADDRESS_LEN-1:0]),
            .i_wr_data  (load_west[g*NUM_SIZE +: NUM_SIZE]),
            .i_rd_run   (w_rd_run),
            .i_rd_step  (w_next_step),
            .i_rd_count (w_next_n),
            .o_lane     (w_west_lane)
        );

        assign north_input[g*NUM_SIZE +: NUM_SIZE] = w_north_lane;
        assign west_input[g*NUM_SIZE +: NUM_SIZE]  = w_west_lane;
    end

    assign load_ready = r_load_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign ce         = r_ce;

endmodule

// File: tb/tb_operand_feeder.sv
// Directed bench for operand_feeder: skew pattern, empty start, full buffer,
// coincident load/start, loads during a run and reset mid-run.
module tb_operand_feeder;

    import accel_pkg::*;

    localparam int W = NUM_SIZE * GRID_SIZE;

    logic         clk;
    logic         rst;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] load_north;
    logic [W-1:0] load_west;
    logic         start;
    logic         busy;
    logic         done;
    logic         ce;
    logic [W-1:0] north_input;
    logic [W-1:0] west_input;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] cap_n    [64];
    logic [W-1:0] cap_w    [64];
    logic         cap_ce   [64];
    logic         cap_busy [64];
    logic         cap_lr   [64];
    int           ce_cnt;
    int           done_cyc;

    operand_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_north  (load_north),
        .load_west   (load_west),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .ce          (ce),
        .north_input (north_input),
        .west_input  (west_input)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_beat(input logic [W-1:0] n, input logic [W-1:0] w);
        load_valid = 1'b1;
        load_north = n;
        load_west  = w;
        checks++;
        if (load_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_ready_before_beat: got %b expected 1", load_ready);
        end
        tick();
        load_valid = 1'b0;
    endtask

    task automatic start_run(input logic with_beat, input logic [W-1:0] n, input logic [W-1:0] w);
        start      = 1'b1;
        load_valid = with_beat;
        load_north = n;
        load_west  = w;
        tick();
        start      = 1'b0;
        load_valid = 1'b0;
    endtask

    // Records outputs from the first cycle after start until done (inclusive).
    task automatic run_capture(input string name, input int max_cyc);
        ce_cnt   = 0;
        done_cyc = -1;
        for (int c = 1; c <= max_cyc; c++) begin
            cap_n[c]    = north_input;
            cap_w[c]    = west_input;
            cap_ce[c]   = ce;
            cap_busy[c] = busy;
            cap_lr[c]   = load_ready;
            if (ce) ce_cnt++;
            if (done) begin
                done_cyc = c;
                break;
            end
            tick();
        end
        checks++;
        if (done_cyc < 0) begin
            failures++;
            $display("FAIL %s_done_timeout: no done within %0d cycles", name, max_cyc);
        end
    endtask

    task automatic check_run(input string name, input int exp_ce);
        checks++;
        if (ce_cnt !== exp_ce) begin
            failures++;
            $display("FAIL %s_ce_count: got %0d expected %0d", name, ce_cnt, exp_ce);
        end
        checks++;
        if (done_cyc !== exp_ce + 1) begin
            failures++;
            $display("FAIL %s_done_cycle: got %0d expected %0d", name, done_cyc, exp_ce + 1);
        end
        for (int c = 1; c <= exp_ce; c++) begin
            checks++;
            if ((cap_ce[c] !== 1'b1) || (cap_busy[c] !== 1'b1)) begin
                failures++;
                $display("FAIL %s_ce_busy_c%0d: got ce=%b busy=%b expected 1/1", name, c, cap_ce[c], cap_busy[c]);
            end
        end
        if (done_cyc > 0) begin
            checks++;
            if ((cap_busy[done_cyc] !== 1'b0) || (cap_ce[done_cyc] !== 1'b0)) begin
                failures++;
                $display("FAIL %s_done_cycle_flags: got busy=%b ce=%b expected 0/0", name, cap_busy[done_cyc], cap_ce[done_cyc]);
            end
        end
    endtask

    task automatic expect_vec(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        load_valid = 1'b0;
        start      = 1'b0;
        load_north = '0;
        load_west  = '0;
        tick();
        tick();
        checks++;
        if ({load_ready, busy, done, ce} !== 4'b0 || north_input !== '0 || west_input !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got lr=%b busy=%b done=%b ce=%b n=%h w=%h expected all 0",
                     load_ready, busy, done, ce, north_input, west_input);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (load_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b expected 1", load_ready);
        end
    endtask

    task automatic test_basic_skew();
        logic [W-1:0] exp_n [4];
        logic [W-1:0] exp_w [4];
        exp_n = '{{16'd0, 16'd1}, {16'd2, 16'd3}, {16'd4, 16'd0}, {16'd0, 16'd0}};
        exp_w = '{{16'd0, 16'd5}, {16'd6, 16'd7}, {16'd8, 16'd0}, {16'd0, 16'd0}};
        load_beat({16'd2, 16'd1}, {16'd6, 16'd5});
        load_beat({16'd4, 16'd3}, {16'd8, 16'd7});
        start_run(1'b0, '0, '0);
        run_capture("skew", 10);
        check_run("skew", 4);
        for (int c = 0; c < 4; c++) begin
            expect_vec($sformatf("skew_north_c%0d", c + 1), cap_n[c + 1], exp_n[c]);
            expect_vec($sformatf("skew_west_c%0d", c + 1), cap_w[c + 1], exp_w[c]);
        end
        tick();
        checks++;
        if (load_ready !== 1'b1) begin
            failures++;
            $display("FAIL skew_ready_after_done: got %b expected 1", load_ready);
        end
    endtask

    task automatic test_empty_start();
        start_run(1'b0, '0, '0);
        run_capture("empty", 5);
        check_run("empty", 0);
        tick();
    endtask

    task automatic test_single_beat_start();
        start_run(1'b1, {16'd71, 16'd70}, {16'd81, 16'd80});
        run_capture("single", 8);
        check_run("single", 3);
        expect_vec("single_north_c1", cap_n[1], {16'd0, 16'd70});
        expect_vec("single_north_c2", cap_n[2], {16'd71, 16'd0});
        expect_vec("single_west_c2", cap_w[2], {16'd81, 16'd0});
        tick();
    endtask

    task automatic test_full_buffer();
        int acc;
        logic took;
        acc = 0;
        for (int k = 0; k < 40; k++) begin
            load_valid = 1'b1;
            load_north = {16'(acc + 100), 16'(acc)};
            load_west  = {16'(acc + 300), 16'(acc + 200)};
            took = load_ready;
            tick();
            if (took) begin
                acc++;
                if (acc == 32) begin
                    checks++;
                    if (load_ready !== 1'b0) begin
                        failures++;
                        $display("FAIL full_ready_drop: got %b expected 0", load_ready);
                    end
                end
            end
        end
        load_valid = 1'b0;
        checks++;
        if (acc !== 32) begin
            failures++;
            $display("FAIL full_accepted: got %0d expected 32", acc);
        end
        start_run(1'b0, '0, '0);
        run_capture("full", 45);
        check_run("full", 34);
        expect_vec("full_north_c1", cap_n[1], {16'd0, 16'd0});
        expect_vec("full_north_c2", cap_n[2], {16'd100, 16'd1});
        expect_vec("full_north_c32", cap_n[32], {16'd130, 16'd31});
        expect_vec("full_north_c33", cap_n[33], {16'd131, 16'd0});
        expect_vec("full_west_c33", cap_w[33], {16'd331, 16'd0});
        expect_vec("full_north_c34", cap_n[34], {16'd0, 16'd0});
        tick();
    endtask

    task automatic test_same_cycle_start();
        load_beat({16'd11, 16'd10}, {16'd21, 16'd20});
        load_beat({16'd13, 16'd12}, {16'd23, 16'd22});
        start_run(1'b1, {16'd15, 16'd14}, {16'd25, 16'd24});
        run_capture("same", 10);
        check_run("same", 5);
        expect_vec("same_north_c1", cap_n[1], {16'd0, 16'd10});
        expect_vec("same_north_c3", cap_n[3], {16'd13, 16'd14});
        expect_vec("same_north_c4", cap_n[4], {16'd15, 16'd0});
        expect_vec("same_west_c4", cap_w[4], {16'd25, 16'd0});
        expect_vec("same_north_c5", cap_n[5], {16'd0, 16'd0});
        tick();
    endtask

    task automatic test_load_during_run();
        int lr_high;
        load_beat({16'd41, 16'd40}, {16'd51, 16'd50});
        load_beat({16'd43, 16'd42}, {16'd53, 16'd52});
        start_run(1'b0, '0, '0);
        load_valid = 1'b1;
        load_north = {16'd99, 16'd99};
        load_west  = {16'd99, 16'd99};
        run_capture("busyload", 10);
        check_run("busyload", 4);
        expect_vec("busyload_north_c2", cap_n[2], {16'd41, 16'd42});
        expect_vec("busyload_west_c3", cap_w[3], {16'd53, 16'd0});
        lr_high = 0;
        for (int c = 1; c <= done_cyc; c++) begin
            if (cap_lr[c] !== 1'b0) lr_high++;
        end
        checks++;
        if (lr_high !== 0) begin
            failures++;
            $display("FAIL busyload_ready_during_run: got %0d ready cycles expected 0", lr_high);
        end
        load_north = {16'd61, 16'd60};
        load_west  = {16'd63, 16'd62};
        tick();
        checks++;
        if (load_ready !== 1'b1) begin
            failures++;
            $display("FAIL busyload_ready_resume: got %b expected 1", load_ready);
        end
        tick();
        load_valid = 1'b0;
        start_run(1'b0, '0, '0);
        run_capture("resume", 8);
        check_run("resume", 3);
        expect_vec("resume_north_c1", cap_n[1], {16'd0, 16'd60});
        expect_vec("resume_west_c2", cap_w[2], {16'd63, 16'd0});
        tick();
    endtask

    task automatic test_reset_mid_run();
        int done_seen;
        load_beat({16'd2, 16'd1}, {16'd6, 16'd5});
        load_beat({16'd4, 16'd3}, {16'd8, 16'd7});
        start_run(1'b0, '0, '0);
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({load_ready, busy, done, ce} !== 4'b0 || north_input !== '0 || west_input !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: got lr=%b busy=%b done=%b ce=%b n=%h w=%h expected all 0",
                     load_ready, busy, done, ce, north_input, west_input);
        end
        tick();
        rst = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (done !== 1'b0 || ce !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            failures++;
            $display("FAIL midreset_no_done: got %0d active cycles expected 0", done_seen);
        end
        checks++;
        if (load_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_ready: got %b expected 1", load_ready);
        end
        start_run(1'b0, '0, '0);
        run_capture("midreset_empty", 5);
        check_run("midreset_empty", 0);
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_skew();
        test_empty_start();
        test_single_beat_start();
        test_full_buffer();
        test_same_cycle_start();
        test_load_during_run();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
